uart_rx_ovs: RTL

Parametrised UART receiver that replaces the fixed-format receiver.
- Configurable data width, parity mode and stop-bit count.
- Samples the line at OVS× the bit rate and takes a 3-sample majority vote per bit.
- Delivers each word with a valid/ready handshake and reports parity, framing and overrun errors.
- Sits between the board RX pin and the command/data parser; frames are format-compatible with the existing uart_tx.

---
 rtl/uart_rx_ovs.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with a 3-sample majority vote per bit,
// configurable data width, parity and stop bits, and a valid/ready output.
// Optional break detection is enabled with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_ovs #(
    parameter int CLK_FREQ    = 100000000,
    parameter int UART_RATE   = 1000000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 1,
    parameter int OVS         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 parity_error_o,
    output logic                 frame_error_o,
    output logic                 overrun_o,
    output logic                 break_o,
    output logic                 busy_o
);
    localparam int DIV = (CLK_FREQ + UART_RATE * OVS / 2) / (UART_RATE * OVS);
    localparam int DW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVS);
    localparam int BW  = 4;

    generate
        if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || OVS < 8 || (OVS % 2) != 0) begin : g_bad_param
            $error("uart_rx_ovs: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
    state_t state, state_n;

    logic                 sync1, rxd_s, prev;
    logic                 fall;
    logic [DW-1:0]        tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic                 tick, vote_tick, vote;
    logic                 s_a, s_b;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err, frm_err, all_zero;
    logic                 word_done, brk;

    assign fall      = prev & ~rxd_s;
    assign tick      = (tick_cnt == DW'(DIV - 1));
    assign vote_tick = tick && (samp_cnt == SW'(OVS / 2 + 1));
    assign vote      = (s_a & s_b) | (s_a & rxd_s) | (s_b & rxd_s);
    assign busy_o    = (state != IDLE);

    // Two-stage synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
            prev  <= 1'b0;
        end else begin
            sync1 <= uart_rxd;
            rxd_s <= sync1;
            prev  <= rxd_s;
        end
    end

    // Tick divider and per-bit sample counter, realigned on each start edge
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && fall)) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
                samp_cnt <= (samp_cnt == SW'(OVS - 1)) ? '0 : samp_cnt + 1'b1;
        end
    end

    // Capture the two samples preceding the vote sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == SW'(OVS / 2 - 1)) s_a <= rxd_s;
            if (samp_cnt == SW'(OVS / 2))     s_b <= rxd_s;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic [SW-1:0] hi_cnt;

    // Count consecutive high ticks while waiting for the line to recover from a break
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_IDLE) hi_cnt <= '0;
        else if (tick)                 hi_cnt <= rxd_s ? hi_cnt + 1'b1 : '0;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic and word-completion strobes
    always_comb begin
        state_n   = state;
        word_done = 1'b0;
        brk       = 1'b0;
        case (state)
            IDLE:   if (fall) state_n = START;
            START:  if (vote_tick) state_n = vote ? IDLE : DATA;
            DATA:   if (vote_tick && bit_cnt == BW'(DATA_BITS - 1))
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (vote_tick) state_n = STOP;
            STOP:   if (vote_tick && bit_cnt == BW'(STOP_BITS - 1)) begin
`ifdef UART_RX_BREAK_DETECT_EN
                        if (all_zero && !vote) begin
                            brk     = 1'b1;
                            state_n = WAIT_IDLE;
                        end else begin
                            word_done = 1'b1;
                            state_n   = IDLE;
                        end
`else
                        word_done = 1'b1;
                        state_n   = IDLE;
`endif
                    end
`ifdef UART_RX_BREAK_DETECT_EN
            WAIT_IDLE: if (tick && rxd_s && hi_cnt == SW'(OVS - 1)) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Frame datapath: shift register, bit counter and error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            all_zero <= 1'b0;
        end else if (vote_tick) begin
            case (state)
                START: begin
                    bit_cnt  <= '0;
                    par_err  <= 1'b0;
                    frm_err  <= 1'b0;
                    all_zero <= 1'b1;
                end
                DATA: begin
                    shreg    <= {vote, shreg[DATA_BITS-1:1]};
                    bit_cnt  <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + 1'b1;
                    all_zero <= all_zero & ~vote;
                end
                PARITY: begin
                    par_err  <= vote ^ (^shreg) ^ (PARITY_MODE == 1);
                    all_zero <= all_zero & ~vote;
                end
                STOP: begin
                    bit_cnt  <= (bit_cnt == BW'(STOP_BITS - 1)) ? '0 : bit_cnt + 1'b1;
                    frm_err  <= frm_err | ~vote;
                    all_zero <= all_zero & ~vote;
                end
                default: ;
            endcase
        end
    end

    // Holding register with valid/ready handshake and overrun reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o         <= '0;
            data_valid_o   <= 1'b0;
            parity_error_o <= 1'b0;
            frame_error_o  <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (word_done) begin
                if (!data_valid_o || data_ready_i) begin
                    data_o         <= shreg;
                    parity_error_o <= par_err;
                    frame_error_o  <= frm_err | ~vote;
                    data_valid_o   <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (data_valid_o && data_ready_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // One-cycle break pulse
    always_ff @(posedge clk) begin
        if (rst) break_o <= 1'b0;
        else     break_o <= brk;
    end
`else
    assign break_o = brk;
`endif

endmodule
